debounce_multi: RTL

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_multi.sv | 129 ++++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//   Multi-channel push-button conditioner. Every channel has its own input
//   synchroniser, debounce counter, edge-pulse generator and long-press
//   detector; channels share only the clock and the reset.
//
// Parameters
//   CHANNELS    number of independent button inputs (1..32)
//   DB_CYCLES   consecutive stable cycles needed to accept a level change
//   LONG_CYCLES cycles button_db must stay high before a long-press pulse
//   INVERT      per-channel bit, 1 = raw input is active-low
//
// Ports
//   clk            rising-edge clock for all state
//   rst_n          asynchronous active-low reset
//   button         raw asynchronous button levels
//   button_db      debounced pressed level (1 = pressed)
//   button_rising  one-cycle pulse when button_db goes 0 -> 1
//   button_falling one-cycle pulse when button_db goes 1 -> 0
//   button_long    one-cycle pulse when a press has been held LONG_CYCLES
//   button_held    level, 1 from the long-press pulse until release
//   any_event      OR of all rising, falling and long pulses
// ---------------------------------------------------------------------------
module debounce_multi #(
    parameter int unsigned         CHANNELS    = 4,
    parameter int unsigned         DB_CYCLES   = 120000,
    parameter int unsigned         LONG_CYCLES = 12000000,
    parameter logic [CHANNELS-1:0] INVERT      = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] button_db,
    output logic [CHANNELS-1:0] button_rising,
    output logic [CHANNELS-1:0] button_falling,
    output logic [CHANNELS-1:0] button_long,
    output logic [CHANNELS-1:0] button_held,
    output logic                any_event
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic              w_p;
            logic              w_diff;
            logic              w_toggle;
            logic              w_long_hit;
            logic              r_sync1;
            logic              r_sync2;
            logic [DB_W-1:0]   r_db_cnt;
            logic [LONG_W-1:0] r_hold_cnt;
            logic              r_db;
            logic              r_rise;
            logic              r_fall;
            logic              r_long;
            logic              r_held;

            // Polarity is normalised before synchronising so that reset
            // (all flops 0) always means "released", even for active-low
            // inputs idling high.
            always_comb begin
                w_p      = button[g] ^ INVERT[g];
                w_diff   = (r_sync2 != r_db);
                w_toggle = w_diff && (r_db_cnt == DB_LAST);
                // A long press is not reported on the very edge the press
                // is being released.
                w_long_hit = r_db && !w_toggle && (r_hold_cnt == LONG_LAST);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1    <= 1'b0;
                    r_sync2    <= 1'b0;
                    r_db_cnt   <= '0;
                    r_hold_cnt <= '0;
                    r_db       <= 1'b0;
                    r_rise     <= 1'b0;
                    r_fall     <= 1'b0;
                    r_long     <= 1'b0;
                    r_held     <= 1'b0;
                end else begin
                    r_sync1 <= w_p;
                    r_sync2 <= r_sync1;

                    // Any return to the accepted level wipes the count.
                    if (!w_diff || w_toggle) begin
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end

                    r_db   <= r_db ^ w_toggle;
                    r_rise <= w_toggle && !r_db;
                    r_fall <= w_toggle && r_db;

                    if (!r_db) begin
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt != LONG_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end

                    r_long <= w_long_hit;

                    if (w_toggle && r_db) begin
                        r_held <= 1'b0;
                    end else if (w_long_hit) begin
                        r_held <= 1'b1;
                    end
                end
            end

            assign button_db[g]      = r_db;
            assign button_rising[g]  = r_rise;
            assign button_falling[g] = r_fall;
            assign button_long[g]    = r_long;
            assign button_held[g]    = r_held;
        end
    endgenerate

    assign any_event = |(button_rising | button_falling | button_long);

endmodule
